// File: rtl/interrupt_controller.sv
// Prioritised maskable interrupt controller: edge-captured pending bits, lowest index wins, one request held until ack then EOI.
// Pin-to-irq latency 2 cycles; irq is held (no preemption) until irq_ack, mask/W1C withdrawal, or reset; readdata lags memread by 1 cycle.
module interrupt_controller #(
  parameter int          NUM_IRQ   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IRQ-1:0]         interrupts,
  input  logic                       memwrite,
  input  logic                       memread,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       irq,
  output logic [$clog2(NUM_IRQ)-1:0] irq_id,
  input  logic                       irq_ack
);

  localparam int ID_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [ID_W-1:0]    inservice;

  logic               hit;
  logic               wr_pend;
  logic               wr_mask;
  logic               wr_eoi;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [ID_W-1:0]    winner;
  logic [31:0]        rd_val;
  logic               unused_bits;

  assign hit     = (dataadr[31:4] == BASE_ADDR[31:4]);
  assign wr_pend = memwrite && hit && (dataadr[3:2] == 2'd0);
  assign wr_mask = memwrite && hit && (dataadr[3:2] == 2'd1);
  assign wr_eoi  = memwrite && hit && (dataadr[3:2] == 2'd2);

  assign rise    = interrupts & ~prev;
  assign req     = pending & mask;
  assign w1c     = wr_pend ? writedata[NUM_IRQ-1:0] : '0;
  assign ack_clr = (state == REQ && irq_ack) ? (NUM_IRQ'(1) << irq_id) : '0;

  assign unused_bits = ^{dataadr[1:0], writedata[31:NUM_IRQ]};

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (dataadr[3:2])
        2'd0: rd_val = 32'(pending);
        2'd1: rd_val = 32'(mask);
        2'd3: begin
          rd_val[ID_W-1:0] = inservice;
          rd_val[8]        = (state == SERVICE);
          rd_val[9]        = irq;
        end
        default: rd_val = '0;
      endcase
    end
  end

  // Runs through reset so a line held high across reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    prev <= interrupts;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      mask      <= '0;
      inservice <= '0;
      irq       <= 1'b0;
      irq_id    <= '0;
      readdata  <= '0;
    end else begin
      // A new edge beats a same-cycle W1C or ack-clear of that bit.
      pending <= (pending & ~(w1c | ack_clr)) | rise;
      if (wr_mask) mask <= writedata[NUM_IRQ-1:0];
      if (memread) readdata <= rd_val;

      case (state)
        IDLE: begin
          if (|req) begin
            state  <= REQ;
            irq    <= 1'b1;
            irq_id <= winner;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq       <= 1'b0;
            inservice <= irq_id;
            state     <= SERVICE;
          end else if (!(pending[irq_id] && mask[irq_id])) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        SERVICE: begin
          if (wr_eoi) begin
            inservice <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: hand-computed expectations on irq/irq_id and register reads.
module tb_interrupt_controller;

  localparam logic [31:0] BASE   = 32'hFFFF_FF00;
  localparam logic [31:0] A_PEND = BASE + 32'h0;
  localparam logic [31:0] A_MASK = BASE + 32'h4;
  localparam logic [31:0] A_EOI  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  interrupts = '0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [2:0]  irq_id;
  logic        irq_ack = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  interrupt_controller #(.NUM_IRQ(8), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .interrupts(interrupts),
    .memwrite  (memwrite),
    .memread   (memread),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0; writedata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    memread = 1'b1; dataadr = a;
    tick();
    memread = 1'b0;
    d = readdata;
  endtask

  task automatic pulse(input logic [7:0] v);
    interrupts = v;
    tick();
    interrupts = '0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_irq", irq, 0);
    chk("rst_irq_id", irq_id, 0);
    chk("rst_readdata", readdata, 0);
    reset = 1'b1;
    tick();
    bus_read(A_PEND, rd); chk("rst_pending", rd, 0);
    bus_read(A_MASK, rd); chk("rst_mask", rd, 0);

    // Single line, ack, EOI
    bus_write(A_MASK, 32'h02);
    pulse(8'h02);
    chk("t1_irq_not_yet", irq, 0);
    tick();
    chk("t1_irq", irq, 1);
    chk("t1_irq_id", irq_id, 1);
    ack();
    chk("t1_irq_after_ack", irq, 0);
    bus_read(A_STAT, rd); chk("t1_status_service", rd, 32'h101);
    bus_read(A_PEND, rd); chk("t1_pending_cleared", rd, 0);
    bus_write(A_EOI, 32'h0);
    bus_read(A_STAT, rd); chk("t1_status_idle", rd, 32'h000);

    // Two simultaneous lines: lowest index first, other raised 2 cycles after EOI
    bus_write(A_MASK, 32'hFF);
    pulse(8'h24);
    tick();
    chk("t2_irq", irq, 1);
    chk("t2_irq_id_2", irq_id, 2);
    ack();
    bus_write(A_EOI, 32'h0);
    chk("t2_irq_low_after_eoi", irq, 0);
    tick();
    chk("t2_irq_reraise", irq, 1);
    chk("t2_irq_id_5", irq_id, 5);
    ack();
    bus_write(A_EOI, 32'h0);
    bus_read(A_PEND, rd); chk("t2_pending_empty", rd, 0);

    // Masked arrival, unmask, then withdraw by W1C while in REQ
    bus_write(A_MASK, 32'h00);
    pulse(8'h08);
    tick();
    chk("t3_masked_no_irq", irq, 0);
    bus_read(A_PEND, rd); chk("t3_pending_08", rd, 32'h08);
    bus_write(A_MASK, 32'h08);
    tick();
    chk("t3_irq", irq, 1);
    chk("t3_irq_id_3", irq_id, 3);
    bus_write(A_PEND, 32'h08);
    tick();
    chk("t3_w1c_drops_irq", irq, 0);
    bus_read(A_STAT, rd); chk("t3_status_idle", rd, 0);
    bus_read(A_PEND, rd); chk("t3_pending_clear", rd, 0);

    // No preemption by a higher-priority arrival while in REQ
    bus_write(A_MASK, 32'hFF);
    pulse(8'h10);
    tick();
    chk("t4_irq_id_4", irq_id, 4);
    pulse(8'h01);
    tick();
    chk("t4_irq_still", irq, 1);
    chk("t4_irq_id_frozen", irq_id, 4);
    ack();
    bus_read(A_PEND, rd); chk("t4_pending_01", rd, 32'h01);
    bus_write(A_EOI, 32'h0);
    tick();
    chk("t4_irq_line0", irq, 1);
    chk("t4_irq_id_0", irq_id, 0);
    ack();
    bus_write(A_EOI, 32'h0);

    // Set beats same-cycle W1C of the same bit
    bus_write(A_MASK, 32'h00);
    interrupts = 8'h02;
    bus_write(A_PEND, 32'h02);
    interrupts = '0;
    bus_read(A_PEND, rd); chk("t5_set_wins", rd, 32'h02);
    bus_write(A_PEND, 32'hFF);
    bus_read(A_PEND, rd); chk("t5_w1c_all", rd, 0);

    // Unmapped and write-only reads return 0
    bus_read(32'h0000_0004, rd); chk("t5_unmapped_read", rd, 0);
    bus_read(A_EOI, rd); chk("t5_eoi_read", rd, 0);

    // Line held high across reset release is not an edge
    interrupts = 8'h40;
    reset = 1'b0;
    repeat (2) tick();
    chk("t6_rst_readdata", readdata, 0);
    reset = 1'b1;
    tick();
    bus_write(A_MASK, 32'h40);
    repeat (4) tick();
    chk("t6_held_no_irq", irq, 0);
    bus_read(A_PEND, rd); chk("t6_held_no_pending", rd, 0);
    interrupts = 8'h00;
    tick();
    interrupts = 8'h40;
    tick();
    tick();
    chk("t6_reraise_irq", irq, 1);
    chk("t6_reraise_id", irq_id, 6);
    reset = 1'b0;
    tick();
    chk("t6_reset_drops_irq", irq, 0);
    chk("t6_reset_irq_id", irq_id, 0);
    reset = 1'b1;
    tick();
    bus_read(A_PEND, rd); chk("t6_reset_pending", rd, 0);
    bus_read(A_MASK, rd); chk("t6_reset_mask", rd, 0);
    interrupts = '0;

    // Ack in the same cycle as a W1C of the requested bit: ack wins
    bus_write(A_MASK, 32'h04);
    pulse(8'h04);
    tick();
    chk("t7_irq_id_2", irq_id, 2);
    irq_ack = 1'b1;
    bus_write(A_PEND, 32'h04);
    irq_ack = 1'b0;
    chk("t7_irq_low", irq, 0);
    bus_read(A_STAT, rd); chk("t7_status_service", rd, 32'h102);
    bus_write(A_EOI, 32'h0);
    bus_read(A_STAT, rd); chk("t7_status_idle", rd, 0);
    bus_write(A_EOI, 32'h0);
    bus_read(A_STAT, rd); chk("t7_eoi_in_idle", rd, 0);
    ack();
    chk("t7_ack_in_idle", irq, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
